sreg_ctrl_mc: RTL and testbench
===============================

Name: sreg_ctrl_mc

Overview:
Parametrised multi-channel successor to the single-chain pixel shift-register controller.
- Accepts one parallel configuration word per transaction over a valid/ready handshake.
- Serialises it MSB-first onto NCH pixel shift-register chains simultaneously, at a programmable strobe rate.
- Captures what falls out of each chain into a readback word, then issues a one-cycle latch pulse.
- Sits between the configuration/readout logic and the pixel-matrix shift chains.

Parameters:
NBITS, 42, bits per chain (≥2)
NCH, 2, number of parallel chains (≥1)
DIV, 1, clk cycles per shift strobe (≥1)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  new word available
in_ready  out  1  controller can accept word
data_in  in  NCH*NBITS  chain c image = data_in[c*NBITS +: NBITS]
readback_en  in  1  sampled with data_in; 1 = return captured word
abort  in  1  cancel current transaction
serial_out  out  NCH  current bit per chain
shift  out  1  strobe; chains sample serial_out on the clk edge where shift=1
sreg_in  in  NCH  chain tail bits
latch  out  1  one-cycle load pulse after last shift
out_valid  out  1  readback word valid
out_ready  in  1  consumer accepts readback
data_out  out  NCH*NBITS  captured chain contents, same channel layout as data_in
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values, with rst high: in_ready=0, shift=0, latch=0, out_valid=0, busy=0, serial_out=0, data_out=0, state=IDLE. Cycle after rst deasserts: in_ready=1.
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid&in_ready: load data_in into shadow register, store readback_en, clear bit counter and divider, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - serial_out[c] = shadow[c*NBITS + NBITS-1] (MSB of remaining image).
  - Divider counts 0..DIV-1; shift=1 in cycles where divider==DIV-1.
  - On each strobe edge:
    - shadow per channel shifts left by 1.
    - capture[c] = {capture[c][NBITS-2:0], sreg_in[c]}.
    - bit counter increments.
  - After the NBITS-th strobe go to LATCH.
- LATCH:
  - latch=1 for exactly one cycle, shift=0, serial_out=0.
  - Next state: DONE if stored readback_en=1, else IDLE.
- DONE:
  - out_valid=1, data_out=capture.
  - Both held stable until out_ready=1, then IDLE.
  - out_valid deasserts in the cycle after acceptance.
- Latency with DIV=1 and accept at cycle 0:
  - strobes in cycles 1..NBITS;
  - latch in cycle NBITS+1;
  - out_valid from cycle NBITS+2.
- General DIV: first strobe in cycle DIV, then one every DIV cycles; latch in cycle NBITS*DIV+1.
- Bit ordering: first bit out of chain c lands in data_out bit c*NBITS+NBITS-1.
- abort:
  - In SHIFT or LATCH: go to IDLE next cycle, no latch pulse, no out_valid, capture discarded.
  - In IDLE or DONE: ignored.
  - Abort has priority over a simultaneous strobe (that strobe's sample is discarded).
- A new transaction is accepted only in IDLE; in_valid elsewhere has no effect. The earliest back-to-back accept is the cycle after DONE/LATCH exits.
- rst mid-transaction: immediate return to reset values; no partial latch.
- shift and latch are never high in the same cycle.

Test Plan:
- NBITS=42, NCH=2, DIV=1; chain0=42'h26B4B4F692A, chain1=~chain0; chains modelled as 42-bit registers preloaded with 42'h155_5555_5555, readback_en=1 -> exactly 42 shift strobes in cycles 1..42; latch in cycle 43; chain registers equal the written images; data_out = preloaded contents; out_valid in cycle 44.
- DIV=3, same data -> shift high every 3rd cycle (first in cycle 3); latch in cycle 127; serial_out stable across each 3-cycle window.
- readback_en=0 -> latch pulse, then in_ready=1 the next cycle; out_valid never asserted.
- out_ready held 0 for 10 cycles in DONE -> out_valid and data_out stable; in_ready=0 throughout; accept on out_ready=1.
- abort asserted on the 20th strobe cycle -> no latch, no out_valid, in_ready=1 next cycle; a following transaction completes normally.
- rst asserted mid-SHIFT -> all outputs zero next cycle; in_valid during rst is ignored.

Source files
------------

// File: rtl/sreg_ctrl_mc.sv
// Serialises one NCH*NBITS word MSB-first onto NCH pixel chains, captures what falls out, then pulses latch.
// Accept-to-latch NBITS*DIV+1 cycles; in_ready only in IDLE; the readback word is held until out_ready.
module sreg_ctrl_mc #(
  parameter int NBITS = 42,
  parameter int NCH   = 2,
  parameter int DIV   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*NBITS-1:0] data_in,
  input  logic                 readback_en,
  input  logic                 abort,
  output logic [NCH-1:0]       serial_out,
  output logic                 shift,
  input  logic [NCH-1:0]       sreg_in,
  output logic                 latch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*NBITS-1:0] data_out,
  output logic                 busy
);

  localparam int W  = NCH * NBITS;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(NBITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);
  // With DIV=1 every SHIFT cycle is a strobe, including the first one.
  localparam logic FIRST_STROBE = (DIV == 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   shadow_q;
  logic [W-1:0]   capture_q;
  logic [W-1:0]   data_out_q;
  logic [DW-1:0]  div_q;
  logic [CW-1:0]  cnt_q;
  logic           rb_q;
  logic           in_ready_q;
  logic           shift_q;
  logic           latch_q;
  logic           out_valid_q;
  logic           busy_q;
  logic [NCH-1:0] serial_q;

  logic [W-1:0]   shadow_sh_d;
  logic [W-1:0]   capture_sh_d;
  logic [NCH-1:0] msb_in_d;
  logic [NCH-1:0] msb_next_d;
  logic [DW-1:0]  div_inc_d;

  always_comb begin
    shadow_sh_d  = '0;
    capture_sh_d = '0;
    msb_in_d     = '0;
    msb_next_d   = '0;
    for (int c = 0; c < NCH; c++) begin
      shadow_sh_d[c*NBITS +: NBITS]  = {shadow_q[c*NBITS +: NBITS-1], 1'b0};
      capture_sh_d[c*NBITS +: NBITS] = {capture_q[c*NBITS +: NBITS-1], sreg_in[c]};
      msb_in_d[c]   = data_in[c*NBITS + NBITS-1];
      msb_next_d[c] = shadow_q[c*NBITS + NBITS-2];
    end
    div_inc_d = div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      capture_q   <= '0;
      data_out_q  <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      rb_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      shift_q     <= 1'b0;
      latch_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      serial_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          shift_q     <= 1'b0;
          latch_q     <= 1'b0;
          out_valid_q <= 1'b0;
          serial_q    <= '0;
          if (in_valid && in_ready_q) begin
            shadow_q   <= data_in;
            capture_q  <= '0;
            rb_q       <= readback_en;
            div_q      <= '0;
            cnt_q      <= '0;
            serial_q   <= msb_in_d;
            shift_q    <= FIRST_STROBE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end

        SHIFT: begin
          // shift_q is high exactly in the strobe cycle, so it doubles as the strobe-edge flag.
          if (abort) begin
            shift_q    <= 1'b0;
            serial_q   <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else if (shift_q) begin
            shadow_q  <= shadow_sh_d;
            capture_q <= capture_sh_d;
            div_q     <= '0;
            if (cnt_q == CNT_LAST) begin
              shift_q  <= 1'b0;
              serial_q <= '0;
              latch_q  <= 1'b1;
              state_q  <= LATCH;
            end else begin
              cnt_q    <= cnt_q + 1'b1;
              serial_q <= msb_next_d;
              shift_q  <= FIRST_STROBE;
            end
          end else begin
            div_q   <= div_inc_d;
            shift_q <= (div_inc_d == DIV_LAST);
          end
        end

        LATCH: begin
          latch_q <= 1'b0;
          if (abort || !rb_q) begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            data_out_q  <= capture_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign serial_out = serial_q;
  assign shift      = shift_q;
  assign latch      = latch_q;
  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sreg_ctrl_mc.sv
// Bench for sreg_ctrl_mc: two instances (DIV=1 and DIV=3) driving modelled 42-bit pixel chains,
// with a cycle-level reference model and a readback scoreboard.
module tb_sreg_ctrl_mc;

  localparam int NB = 42;
  localparam logic [NB-1:0] IMG0 = 42'h26B4B4F692A;
  localparam logic [NB-1:0] PRE  = 42'h155_5555_5555;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid_a [2];
  logic          in_ready_a [2];
  logic          rb_a [2];
  logic          abort_a [2];
  logic          shift_a [2];
  logic          latch_a [2];
  logic          out_valid_a [2];
  logic          out_ready_a [2];
  logic          busy_a [2];
  logic [2*NB-1:0] data_in_a [2];
  logic [2*NB-1:0] data_out_a [2];
  logic [1:0]    serial_a [2];
  logic [1:0]    sreg_a [2];

  logic          pre_req [2];
  logic [NB-1:0] pre_val [2][2];
  logic [NB-1:0] chain [2][2];

  int checks;
  int errors;
  logic [2*NB-1:0] sbq0 [$];
  logic [2*NB-1:0] sbq1 [$];

  int            ph [2];
  longint        t0 [2];
  bit            rbm [2];
  logic [NB-1:0] img [2][2];
  bit            rst_prev;
  longint        cyc;

  sreg_ctrl_mc #(.NBITS(NB), .NCH(2), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .data_in(data_in_a[0]), .readback_en(rb_a[0]), .abort(abort_a[0]),
    .serial_out(serial_a[0]), .shift(shift_a[0]), .sreg_in(sreg_a[0]), .latch(latch_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .data_out(data_out_a[0]),
    .busy(busy_a[0])
  );

  sreg_ctrl_mc #(.NBITS(NB), .NCH(2), .DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .data_in(data_in_a[1]), .readback_en(rb_a[1]), .abort(abort_a[1]),
    .serial_out(serial_a[1]), .shift(shift_a[1]), .sreg_in(sreg_a[1]), .latch(latch_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .data_out(data_out_a[1]),
    .busy(busy_a[1])
  );

  // Physical chain model: shifts in serial_out on every strobe edge, tail is the MSB.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (pre_req[d]) chain[d][c] <= pre_val[d][c];
        else if (shift_a[d]) chain[d][c] <= {chain[d][c][NB-2:0], serial_a[d][c]};
      end
    end
  end

  assign sreg_a[0] = {chain[0][1][NB-1], chain[0][0][NB-1]};
  assign sreg_a[1] = {chain[1][1][NB-1], chain[1][0][NB-1]};

  // Monitor: reference model of the expected cycle behaviour plus readback scoreboard.
  initial begin
    rst_prev = 1'b1;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0;
      t0[d] = 0;
      rbm[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin : mon
        int dv;
        int j;
        longint k;
        logic [6:0] ev;
        logic [6:0] av;
        logic [2*NB-1:0] front;
        bit have;
        dv = (d == 0) ? 1 : 3;
        k = cyc - t0[d];
        ev = '0;
        if (!rst_prev) begin
          case (ph[d])
            0: ev[6] = 1'b1;
            1: begin
              ev[2] = 1'b1;
              if ((k % dv) == 0 && (k / dv) >= 1 && (k / dv) <= NB) ev[5] = 1'b1;
              if (k == NB*dv + 1) ev[4] = 1'b1;
              if (k <= NB*dv) begin
                j = int'((k - 1) / dv);
                for (int c = 0; c < 2; c++) ev[c] = img[d][c][NB-1-j];
              end
            end
            default: begin
              ev[3] = 1'b1;
              ev[2] = 1'b1;
            end
          endcase
        end
        av = {in_ready_a[d], shift_a[d], latch_a[d], out_valid_a[d], busy_a[d], serial_a[d]};
        checks++;
        if (av !== ev) begin
          errors++;
          $display("FAIL ctrl_outputs dut%0d cycle %0d: got %b expected %b (in_ready,shift,latch,out_valid,busy,serial[1:0])",
                   d, cyc, av, ev);
        end
        if (rst_prev) begin
          checks++;
          if (data_out_a[d] !== '0) begin
            errors++;
            $display("FAIL reset_data_out dut%0d: got %h expected 0", d, data_out_a[d]);
          end
        end
        if (!rst_prev && ph[d] == 1 && k == NB*dv + 1) begin
          for (int c = 0; c < 2; c++) begin
            checks++;
            if (chain[d][c] !== img[d][c]) begin
              errors++;
              $display("FAIL chain_image dut%0d ch%0d: got %h expected %h", d, c, chain[d][c], img[d][c]);
            end
          end
        end
        if (out_valid_a[d] === 1'b1) begin
          have = (d == 0) ? (sbq0.size() > 0) : (sbq1.size() > 0);
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL readback_unexpected dut%0d: got data_out %h expected no out_valid", d, data_out_a[d]);
          end else begin
            front = (d == 0) ? sbq0[0] : sbq1[0];
            if (data_out_a[d] !== front) begin
              errors++;
              $display("FAIL readback_data dut%0d: got %h expected %h", d, data_out_a[d], front);
            end
            if (out_ready_a[d] === 1'b1) begin
              if (d == 0) void'(sbq0.pop_front());
              else void'(sbq1.pop_front());
            end
          end
        end
        if (rst) ph[d] = 0;
        else begin
          case (ph[d])
            0: if (in_valid_a[d] && !rst_prev) begin
              ph[d] = 1;
              t0[d] = cyc;
              rbm[d] = rb_a[d];
              img[d][0] = data_in_a[d][NB-1:0];
              img[d][1] = data_in_a[d][2*NB-1:NB];
            end
            1: if (abort_a[d]) ph[d] = 0;
               else if (k == NB*dv + 1) ph[d] = rbm[d] ? 2 : 0;
            default: if (out_ready_a[d]) ph[d] = 0;
          endcase
        end
      end
      rst_prev = rst;
      cyc++;
    end
  end

  function automatic logic [NB-1:0] r42();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[NB-1:0];
  endfunction

  task automatic timeout_check(input bit ok, input int d, input string what);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_%s dut%0d: got no event expected one within bound", what, d);
    end
  endtask

  // Preload chains, present a word and wait for the handshake.
  task automatic issue(input int d, input logic [NB-1:0] i0, input logic [NB-1:0] i1, input logic rb,
                       input logic [NB-1:0] p0, input logic [NB-1:0] p1, input bit push);
    bit ok;
    int n;
    pre_val[d][0] = p0;
    pre_val[d][1] = p1;
    pre_req[d] = 1'b1;
    @(posedge clk); #1;
    pre_req[d] = 1'b0;
    data_in_a[d] = {i1, i0};
    rb_a[d] = rb;
    in_valid_a[d] = 1'b1;
    if (push) begin
      if (d == 0) sbq0.push_back({p1, p0});
      else sbq1.push_back({p1, p0});
    end
    ok = 1'b0;
    n = 0;
    while (!ok && n < 60) begin
      @(negedge clk);
      if (in_ready_a[d] === 1'b1) ok = 1'b1;
      n++;
    end
    timeout_check(ok, d, "accept");
    @(posedge clk); #1;
    in_valid_a[d] = 1'b0;
    data_in_a[d] = {r42(), r42()};
    rb_a[d] = 1'($urandom_range(0, 1));
  endtask

  task automatic run_txn(input int d, input logic [NB-1:0] i0, input logic [NB-1:0] i1, input logic rb,
                         input logic [NB-1:0] p0, input logic [NB-1:0] p1, input int abort_at, input int hold);
    bit ok;
    int n;
    int dv;
    dv = (d == 0) ? 1 : 3;
    issue(d, i0, i1, rb, p0, p1, rb && abort_at == 0);
    if (abort_at > 0) begin
      repeat (abort_at*dv - 1) @(posedge clk);
      #1 abort_a[d] = 1'b1;
      @(posedge clk); #1;
      abort_a[d] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end else if (rb) begin
      ok = 1'b0;
      n = 0;
      while (!ok && n < NB*dv + 20) begin
        @(negedge clk);
        if (out_valid_a[d] === 1'b1) ok = 1'b1;
        n++;
      end
      timeout_check(ok, d, "out_valid");
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        abort_a[d] = 1'($urandom_range(0, 1));
        in_valid_a[d] = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      abort_a[d] = 1'b0;
      in_valid_a[d] = 1'b0;
      out_ready_a[d] = 1'b1;
      @(posedge clk); #1;
      out_ready_a[d] = 1'b0;
    end else begin
      ok = 1'b0;
      n = 0;
      while (!ok && n < NB*dv + 20) begin
        @(negedge clk);
        if (busy_a[d] === 1'b0) ok = 1'b1;
        n++;
      end
      timeout_check(ok, d, "idle");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid_a[d] = 1'b0;
      rb_a[d] = 1'b0;
      abort_a[d] = 1'b0;
      out_ready_a[d] = 1'b0;
      data_in_a[d] = '0;
      pre_req[d] = 1'b0;
      pre_val[d][0] = '0;
      pre_val[d][1] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_txn(0, IMG0, ~IMG0, 1'b1, PRE, PRE, 0, 0);
    run_txn(1, IMG0, ~IMG0, 1'b1, PRE, PRE, 0, 0);
    run_txn(0, r42(), r42(), 1'b0, r42(), r42(), 0, 0);
    run_txn(1, r42(), r42(), 1'b0, r42(), r42(), 0, 0);
    run_txn(0, r42(), r42(), 1'b1, r42(), r42(), 0, 10);
    run_txn(1, r42(), r42(), 1'b1, r42(), r42(), 0, 10);
    run_txn(0, r42(), r42(), 1'b1, r42(), r42(), 20, 0);
    run_txn(0, r42(), r42(), 1'b1, r42(), r42(), 0, 1);
    run_txn(1, r42(), r42(), 1'b1, r42(), r42(), 20, 0);
    run_txn(1, r42(), r42(), 1'b1, r42(), r42(), 0, 2);

    // Reset in the middle of a shift, with in_valid held high during reset.
    issue(0, r42(), r42(), 1'b1, r42(), r42(), 1'b0);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    in_valid_a[0] = 1'b1;
    in_valid_a[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    in_valid_a[0] = 1'b0;
    in_valid_a[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_txn(0, r42(), r42(), 1'b1, r42(), r42(), 0, 0);

    for (int i = 0; i < 10; i++) begin
      int d;
      int ab;
      d = $urandom_range(0, 1);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NB)) : 0;
      run_txn(d, r42(), r42(), 1'($urandom_range(0, 1)), r42(), r42(), ab, int'($urandom_range(0, 4)));
    end

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (sbq0.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain dut0: got %0d pending expected 0", sbq0.size());
    end
    checks++;
    if (sbq1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain dut1: got %0d pending expected 0", sbq1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
